// File: rtl/serial_adder_if.sv
// ============================================================================
//  Module      : serial_adder_if
//  Description : Start/done handshake and result bundle for serial_adder.
//                The sub lane exists only when SERIAL_ADDER_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] Y;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, A, B,
        input  Y, carry, overflow, busy, done
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, A, B,
        output Y, carry, overflow, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//                Define SERIAL_ADDER_SUB_EN to add the A - B mode (sub port).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_adder_if.slave bus
);
    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    logic [WIDTH-1:0]   r_sh;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_y;
    logic               r_carry;
    logic               r_ovf;

    logic               w_s;
    logic               w_c_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin;

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in = bus.sub ? ~bus.B : bus.B;
    assign w_cin  = bus.sub;
`else
    assign w_b_in = bus.B;
    assign w_cin  = 1'b0;
`endif

    assign w_s      = r_ra[0] ^ r_rb[0] ^ r_c;
    assign w_c_nxt  = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);
    assign w_sh_nxt = {w_s, r_sh[WIDTH-1:1]};
    assign w_last   = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_sh    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= bus.A;
            r_rb  <= w_b_in;
            r_c   <= w_cin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
            r_c   <= w_c_nxt;
            r_sh  <= w_sh_nxt;
            r_cnt <= r_cnt + 1'b1;
            // r_c still holds the carry into the MSB on the final bit.
            if (w_last) begin
                r_y     <= w_sh_nxt;
                r_carry <= w_c_nxt;
                r_ovf   <= r_c ^ w_c_nxt;
            end
        end
    end

    assign bus.Y        = r_y;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_ovf;
    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed self-checking bench for serial_adder (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             carry;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        logic [WIDTH-1:0] x;
        logic [WIDTH:0]   full;
        exp_t             e;
        x     = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, s};
        e.y   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        e.ovf = (a[WIDTH-1] == x[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Drives one request for a single edge and records its expected result.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        bus.A     = a;
        bus.B     = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = s;
`endif
        bus.start = 1'b1;
        sb.push_back(model(a, b, s));
        tick();
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        check("busy_after_start", {15'd0, bus.busy}, 16'd1);
    endtask

    task automatic expect_done(input int cycles, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (bus.done !== 1'b1 && n < 3 * WIDTH + 4) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 16'(n), 16'(cycles));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_Y"},     16'(bus.Y), 16'(e.y));
            check({tag, "_carry"}, {15'd0, bus.carry}, {15'd0, e.carry});
            check({tag, "_ovf"},   {15'd0, bus.overflow}, {15'd0, e.ovf});
            check({tag, "_busy"},  {15'd0, bus.busy}, 16'd0);
        end
    endtask

    task automatic check_idle(input string tag, input logic [WIDTH-1:0] y);
        tick();
        check({tag, "_done_low"}, {15'd0, bus.done}, 16'd0);
        check({tag, "_Y_held"},   16'(bus.Y), 16'(y));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        tick();
        tick();
        check("rst_Y",     16'(bus.Y), 16'd0);
        check("rst_carry", {15'd0, bus.carry}, 16'd0);
        check("rst_ovf",   {15'd0, bus.overflow}, 16'd0);
        check("rst_busy",  {15'd0, bus.busy}, 16'd0);
        check("rst_done",  {15'd0, bus.done}, 16'd0);
        rst = 1'b0;
        tick();

        // Basic add, then unsigned wrap.
        launch(4'b0011, 4'b0100, 1'b0);
        expect_done(WIDTH, "basic");
        check("basic_Y_const", 16'(bus.Y), 16'b0111);
        check_idle("basic", 4'b0111);
        launch(4'b1111, 4'b0001, 1'b0);
        expect_done(WIDTH, "wrap");
        check("wrap_carry_const", {15'd0, bus.carry}, 16'd1);
        check_idle("wrap", 4'b0000);
        tick();

        // Signed overflow, then a back-to-back request in the done cycle.
        launch(4'b0111, 4'b0001, 1'b0);
        expect_done(WIDTH, "sovf");
        check("sovf_ovf_const", {15'd0, bus.overflow}, 16'd1);
        launch(4'b1000, 4'b1000, 1'b0);
        expect_done(WIDTH, "b2b");
        check("b2b_Y_const", 16'(bus.Y), 16'b0000);
        check_idle("b2b", 4'b0000);

        // Start while busy is dropped.
        launch(4'b0010, 4'b0010, 1'b0);
        tick();
        bus.A     = 4'b1111;
        bus.B     = 4'b1111;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_done(WIDTH - 2, "busy_drop");
        for (int i = 0; i < 2 * WIDTH; i++) begin
            check_idle("busy_drop", 4'b0100);
        end
        check("busy_drop_sb", 16'(sb.size()), 16'd0);

        // Reset mid-operation aborts without a done pulse.
        launch(4'b0101, 4'b0101, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check("midrst_Y",     16'(bus.Y), 16'd0);
        check("midrst_carry", {15'd0, bus.carry}, 16'd0);
        check("midrst_ovf",   {15'd0, bus.overflow}, 16'd0);
        check("midrst_busy",  {15'd0, bus.busy}, 16'd0);
        check("midrst_done",  {15'd0, bus.done}, 16'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            check_idle("midrst", 4'b0000);
        end
        launch(4'b0101, 4'b0101, 1'b0);
        expect_done(WIDTH, "after_rst");
        check("after_rst_Y_const", 16'(bus.Y), 16'b1010);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        launch(4'b1010, 4'b0011, 1'b1);
        expect_done(WIDTH, "sub1");
        check("sub1_Y_const", 16'(bus.Y), 16'b0111);
        launch(4'b0101, 4'b1001, 1'b1);
        expect_done(WIDTH, "sub2");
        check("sub2_Y_const", 16'(bus.Y), 16'b1100);
        launch(4'b0001, 4'b0001, 1'b1);
        expect_done(WIDTH, "sub3");
        check("sub3_carry_const", {15'd0, bus.carry}, 16'd1);
        tick();
`endif

        // A short run of random back-to-back operations.
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             s;
            a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            launch(a, b, s);
            expect_done(WIDTH, "rand");
        end
        tick();
        check("final_sb", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
